div_unit: RTL and testbench

- Multicycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the EX stage, beside the single-cycle ALU.
- Sequences one internal subtractor, built as the same adder instance with inverted operand and carry-in 1, over a restoring shift-subtract loop of one quotient bit per cycle.
- The hazard unit stalls the pipeline while o_busy is high.
- The result is taken on the o_valid pulse.

---
 rtl/div_if.sv | 37 +++
 rtl/div_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_div_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if -- request/response bundle between the EX stage and div_unit.
//
// Signals (named from the divider's point of view):
//   i_start  : request, sampled only while the divider is idle
//   i_op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_rs1    : dividend
//   i_rs2    : divisor
//   i_flush  : synchronous kill from a branch/trap redirect
//   o_busy   : divider occupied (pipeline must stall)
//   o_valid  : one-cycle result strobe
//   o_result : quotient or remainder of the latched op
//
// Modports: master (EX stage / requester), slave (div_unit).
// -----------------------------------------------------------------------------
interface div_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_rs1;
  logic [WIDTH-1:0] i_rs2;
  logic             i_flush;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_start, i_op, i_rs1, i_rs2, i_flush,
    input  o_busy, o_valid, o_result
  );

  modport slave (
    input  i_start, i_op, i_rs1, i_rs2, i_flush,
    output o_busy, o_valid, o_result
  );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multicycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
//
// Restoring shift-subtract divider producing one quotient bit per cycle on
// operand magnitudes, followed by a sign fix-up. A single subtractor
// (adder with inverted B operand and carry-in 1) serves both the per-cycle
// trial subtraction and, in IDLE, the optional magnitude compare.
//
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : div_if.slave (i_start, i_op, i_rs1, i_rs2, i_flush,
//             o_busy, o_valid, o_result)
//
// Parameters:
//   WIDTH : operand/result width
//   CNT_W : iteration counter width, 2**CNT_W > WIDTH
//
// Build option:
//   DIV_EARLY_OUT_EN : when defined, |dividend| < |divisor| (divisor nonzero)
//                      completes straight from IDLE with quotient 0 and
//                      remainder = |dividend|. When undefined such operands
//                      run the full loop and yield the same result.
//
// Timing: start accepted at edge T0 -> CALC for WIDTH cycles -> DONE
// (o_valid) in cycle WIDTH+1. Divide-by-zero, signed overflow (and early-out
// if enabled) reach DONE in cycle 1.
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  div_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_next;

  logic             r_rem_op;     // latched i_op[1]: 1 = REM/REMU
  logic             r_neg1;       // dividend was negative (signed ops only)
  logic             r_neg2;       // divisor was negative (signed ops only)
  logic             r_special;    // result registers already hold final value
  logic [WIDTH-1:0] r_dvd;        // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] r_dvs;        // divisor magnitude
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_result;     // last delivered result
  logic [CNT_W-1:0] r_cnt;

  // ---------------------------------------------------------------------------
  // Operand decode in IDLE
  // ---------------------------------------------------------------------------
  logic             w_signed;
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_early;
  logic             w_accept;

  assign w_signed   = ~bus.i_op[0];
  assign w_neg1     = w_signed & bus.i_rs1[WIDTH-1];
  assign w_neg2     = w_signed & bus.i_rs2[WIDTH-1];
  assign w_mag1     = w_neg1 ? -bus.i_rs1 : bus.i_rs1;
  assign w_mag2     = w_neg2 ? -bus.i_rs2 : bus.i_rs2;
  assign w_div_zero = (bus.i_rs2 == '0);
  assign w_ovf      = w_signed && (bus.i_rs1 == MIN_NEG) && (bus.i_rs2 == '1);
  assign w_accept   = (r_state == S_IDLE) && bus.i_start && !bus.i_flush;

  // ---------------------------------------------------------------------------
  // Shared subtractor: a - b = a + ~b + 1, borrow when carry-out is 0.
  // The partial remainder is carried at WIDTH+1 bits: with an unsigned divisor
  // above 2**(WIDTH-1) the shifted remainder can exceed WIDTH bits before the
  // subtraction brings it back below the divisor.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_sub_a;
  logic [WIDTH:0]   w_sub_b;
  logic [WIDTH+1:0] w_sub_sum;
  logic             w_borrow;
  logic [WIDTH-1:0] w_diff;
  logic             w_unused_diff_msb;   // always 0 whenever the diff is used

  assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_sub_a     = (r_state == S_CALC) ? w_rem_shift    : {1'b0, w_mag1};
  assign w_sub_b     = (r_state == S_CALC) ? {1'b0, r_dvs}  : {1'b0, w_mag2};
  assign w_sub_sum   = {1'b0, w_sub_a} + {1'b0, ~w_sub_b} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_borrow    = ~w_sub_sum[WIDTH+1];
  assign w_diff      = w_sub_sum[WIDTH-1:0];
  assign w_unused_diff_msb = w_sub_sum[WIDTH];

`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_borrow & ~w_div_zero;
`else
  assign w_early = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Result formation in DONE
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_final;
  logic             w_valid;

  assign w_quot_fix = (r_neg1 ^ r_neg2) ? -r_quot : r_quot;
  assign w_rem_fix  = r_neg1 ? -r_rem : r_rem;
  // Special cases store the architecturally defined values unmodified.
  assign w_final    = r_special ? (r_rem_op ? r_rem : r_quot)
                                : (r_rem_op ? w_rem_fix : w_quot_fix);
  // Flush kills completion in the same cycle.
  assign w_valid    = (r_state == S_DONE) && !bus.i_flush;

  assign bus.o_valid  = w_valid;
  assign bus.o_busy   = (r_state != S_IDLE);
  assign bus.o_result = w_valid ? w_final : r_result;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_div_zero || w_ovf || w_early) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.i_flush) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem_op  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_special <= 1'b0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_rem_op  <= bus.i_op[1];
        r_neg1    <= w_neg1;
        r_neg2    <= w_neg2;
        r_special <= w_div_zero | w_ovf;
        r_dvs     <= w_mag2;
        r_cnt     <= CNT_W'(WIDTH-1);
        if (w_div_zero) begin
          r_dvd  <= '0;
          r_quot <= '1;
          r_rem  <= bus.i_rs1;
        end else if (w_ovf) begin
          r_dvd  <= '0;
          r_quot <= MIN_NEG;
          r_rem  <= '0;
        end else if (w_early) begin
          r_dvd  <= '0;
          r_quot <= '0;
          r_rem  <= w_mag1;
        end else begin
          r_dvd  <= w_mag1;
          r_quot <= '0;
          r_rem  <= '0;
        end
      end else if ((r_state == S_CALC) && !bus.i_flush) begin
        r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
        r_quot <= {r_quot[WIDTH-2:0], ~w_borrow};
        // After a successful subtract the difference is below the divisor, and
        // after a borrow the shifted remainder is; either fits in WIDTH bits.
        r_rem  <= w_borrow ? w_rem_shift[WIDTH-1:0] : w_diff;
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      if (w_valid) begin
        r_result <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic rst_n;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_res;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;     // cycle of o_valid on the normal build
    bit          early;   // completes in cycle 1 when early-out is built in
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge. Issues one request and follows it
  // to completion, checking latency, busy, result and the cycle after.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int got;
    bit busy_ok;
    logic [31:0] res;
    got = 0;
    busy_ok = 1'b1;
    res = '0;
    bus.i_op = op;
    bus.i_rs1 = a;
    bus.i_rs2 = b;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (!bus.o_busy) busy_ok = 1'b0;
      if (bus.o_valid) begin
        got = k;
        res = bus.o_result;
        break;
      end
      @(posedge clk); #1;
    end
    chk({name, "_latency"}, got, lat);
    chk({name, "_result"}, res, exp);
    chk({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
    @(posedge clk); #1;
    chk({name, "_valid_after"}, {31'b0, bus.o_valid}, 32'd0);
    chk({name, "_busy_after"}, {31'b0, bus.o_busy}, 32'd0);
    chk({name, "_hold"}, bus.o_result, exp);
    last_res = exp;
  endtask

  initial begin
    int nvalid;
    int got;
    logic [31:0] res;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33, 1'b0};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33, 1'b0};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 1'b0};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 1'b0};
    vecs[4]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1'b0};
    vecs[5]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          1,  1'b0};
    vecs[6]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1,  1'b0};
    vecs[7]  = '{OP_REMU, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1,  1'b0};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1'b0};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1'b0};
    vecs[10] = '{OP_DIVU, 32'd3,          32'd10,         32'd0,          33, 1'b1};
    vecs[11] = '{OP_REMU, 32'd3,          32'd10,         32'd3,          33, 1'b1};
    vecs[12] = '{OP_DIV,  32'hFFFF_FFFD,  32'd10,         32'd0,          33, 1'b1};
    vecs[13] = '{OP_REM,  32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  33, 1'b1};
    vecs[14] = '{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          33, 1'b0};
    vecs[15] = '{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  33, 1'b0};
    vecs[16] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, 1'b0};
    vecs[17] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, 1'b0};
    vecs[18] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 1'b1};
    vecs[19] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33, 1'b0};

    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_op = 2'b00;
    bus.i_rs1 = '0;
    bus.i_rs2 = '0;
    bus.i_flush = 1'b0;
    last_res = '0;

    #2;
    chk("reset_busy",   {31'b0, bus.o_busy},  32'd0);
    chk("reset_valid",  {31'b0, bus.o_valid}, 32'd0);
    chk("reset_result", bus.o_result,         32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             (vecs[i].early && EARLY_EN) ? 1 : vecs[i].lat);
    end

    // Flush in cycle 10 of DIVU 1000/3: no o_valid, idle from cycle 11, result held
    bus.i_op = OP_DIVU; bus.i_rs1 = 32'd1000; bus.i_rs2 = 32'd3;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    nvalid = 0;
    for (int k = 1; k <= 45; k++) begin
      bus.i_flush = (k == 10);
      if (bus.o_valid) nvalid++;
      if (k == 9)  chk("flush_busy_c9",  {31'b0, bus.o_busy}, 32'd1);
      if (k == 11) chk("flush_busy_c11", {31'b0, bus.o_busy}, 32'd0);
      @(posedge clk); #1;
    end
    bus.i_flush = 1'b0;
    chk("flush_no_valid", nvalid, 32'd0);
    chk("flush_hold",     bus.o_result, last_res);

    // Flush in IDLE together with start: start is dropped
    bus.i_op = OP_DIVU; bus.i_rs1 = 32'd50; bus.i_rs2 = 32'd5;
    bus.i_start = 1'b1; bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_flush = 1'b0;
    chk("idle_flush_busy", {31'b0, bus.o_busy}, 32'd0);
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.o_valid) nvalid++;
      @(posedge clk); #1;
    end
    chk("idle_flush_no_valid", nvalid, 32'd0);

    // Second start during cycles 2..32 is ignored
    bus.i_op = OP_DIVU; bus.i_rs1 = 32'd100; bus.i_rs2 = 32'd7;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    got = 0; res = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k >= 2 && k <= 32) begin
        bus.i_start = 1'b1; bus.i_op = OP_REMU; bus.i_rs1 = 32'd1000; bus.i_rs2 = 32'd3;
      end else begin
        bus.i_start = 1'b0;
      end
      if (bus.o_valid) begin
        got = k; res = bus.o_result;
        break;
      end
      @(posedge clk); #1;
    end
    bus.i_start = 1'b0;
    chk("busy_start_latency", got, 32'd33);
    chk("busy_start_result",  res, 32'd14);
    @(posedge clk); #1;
    chk("busy_start_idle", {31'b0, bus.o_busy}, 32'd0);
    last_res = 32'd14;

    // Asynchronous reset in cycle 20 of an op
    bus.i_op = OP_DIVU; bus.i_rs1 = 32'd1000; bus.i_rs2 = 32'd3;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", {31'b0, bus.o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   {31'b0, bus.o_busy},  32'd0);
    chk("midrst_valid",  {31'b0, bus.o_valid}, 32'd0);
    chk("midrst_result", bus.o_result,         32'd0);
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.o_valid) nvalid++;
    end
    chk("midrst_no_valid", nvalid, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_reset_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
